vga_sync_gen: RTL and testbench
===============================

Name: vga_sync_gen

Overview:
- Consumes the pixel-rate tick from the VGA clock divider and produces the 640x480 @ ~60 Hz raster timing: hsync, vsync, video_on, and the current pixel coordinates for the display/render logic.
- Runs on the single system clock. Advances only on cycles where pixel_en is high, so all downstream display elements share one clock domain.
- Sits between the clock divider and the frame renderer / VGA pins.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_ACTIVE, 0, polarity of hsync/vsync during the pulse (0 = active-low)

Ports:
- clock  in  1  system clock; the only clock
- reset  in  1  asynchronous, active-high reset
- pixel_en  in  1  one-cycle pixel tick from the divider; advance raster when high
- pixel_x  out  10  current column, 0..H_TOTAL-1
- pixel_y  out  10  current line, 0..V_TOTAL-1
- hsync  out  1  horizontal sync to the connector
- vsync  out  1  vertical sync to the connector
- video_on  out  1  high when (pixel_x, pixel_y) is in the visible area
- line_start  out  1  one-clock pulse when pixel_x wraps to 0
- frame_start  out  1  one-clock pulse when the raster wraps to (0,0)
- frame_count  out  8  frames completed since reset, wraps 255->0

Behaviour:
- Derived constants: H_TOTAL = sum of the H_* values (800); V_TOTAL = sum of the V_* values (525).
- Reset (asynchronous, active-high; all outputs registered): pixel_x=0, pixel_y=0, hsync=vsync=~SYNC_ACTIVE, video_on=0, line_start=0, frame_start=0, frame_count=0. Reset mid-frame abandons the frame immediately, with no partial-line completion.
- When pixel_en=0, all outputs hold, except line_start and frame_start, which drop to 0.
- When pixel_en=1, at the clock edge:
  - If pixel_x < H_TOTAL-1: pixel_x <= pixel_x+1.
  - Otherwise: pixel_x <= 0, line_start <= 1, and pixel_y advances. If pixel_y = V_TOTAL-1: pixel_y <= 0, frame_start <= 1, frame_count <= frame_count+1 (mod 256).
- Decoded outputs are computed from the next (x,y) and registered in the same edge, so they are always consistent with pixel_x/pixel_y (zero latency relative to the coordinates):
  - video_on = (x < H_VISIBLE) && (y < V_VISIBLE)
  - hsync = SYNC_ACTIVE when H_VISIBLE+H_FRONT <= x < H_VISIBLE+H_FRONT+H_SYNC (656..751), else ~SYNC_ACTIVE
  - vsync = SYNC_ACTIVE when V_VISIBLE+V_FRONT <= y < V_VISIBLE+V_FRONT+V_SYNC (490..491), else ~SYNC_ACTIVE. vsync depends only on y, so it changes on line boundaries.
- video_on stays 0 after reset until the first pixel_en. The raster then sits at (1,0), so the first frame after reset is one pixel short. This is accepted.
- Counters never exceed H_TOTAL-1 / V_TOTAL-1. Out-of-range states are unreachable and need no recovery logic.
- line_start and frame_start coincide at the frame wrap. Both are exactly one clock wide even if pixel_en is held high continuously.
- Continuous pixel_en: period = 800 clocks per line, 420 000 per frame.

Test Plan:
- Reset asserted mid-frame (x=300, y=200) -> next sample shows x=0, y=0, hsync=vsync=1, video_on=0, frame_count=0, without waiting for a clock edge.
- pixel_en held high from reset -> hsync low exactly on x=656..751 (96 clocks), period 800; video_on high on x=0..639 with y<480; line_start pulses when x returns to 0.
- Run a full frame -> vsync low for y=490..491 (1600 pixel ticks); frame_start single-clock pulse at (0,0) after 420 000 ticks from first wrap; frame_count increments by 1 each frame.
- pixel_en toggled 1-of-4 clocks -> coordinates advance only on enabled cycles; line_start/frame_start still exactly one clock wide; hsync width = 96 ticks = 384 clocks.
- Run 256 frames -> frame_count wraps 255->0 at the frame_start edge.
- x=799, y=524 with pixel_en=1 -> next edge x=0, y=0, line_start=1, frame_start=1, video_on=1, hsync=vsync=1.

Source files
------------

// File: rtl/vga_sync_gen.sv
// 640x480 raster timing generator: pixel/line counters advanced by the pixel tick,
// with registered sync, blanking and start-of-line/frame strobes aligned to the coordinates.
module vga_sync_gen #(
   parameter int H_VISIBLE   = 640,
   parameter int H_FRONT     = 16,
   parameter int H_SYNC      = 96,
   parameter int H_BACK      = 48,
   parameter int V_VISIBLE   = 480,
   parameter int V_FRONT     = 10,
   parameter int V_SYNC      = 2,
   parameter int V_BACK      = 33,
   parameter int SYNC_ACTIVE = 0
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       pixel_en,
   output logic [9:0] pixel_x,
   output logic [9:0] pixel_y,
   output logic       hsync,
   output logic       vsync,
   output logic       video_on,
   output logic       line_start,
   output logic       frame_start,
   output logic [7:0] frame_count
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
   localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
   localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
   localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);
   localparam logic       SYNC_ON  = (SYNC_ACTIVE != 0);

   logic [9:0] x_next;
   logic [9:0] y_next;
   logic       x_wrap;
   logic       y_wrap;

   always_comb begin
      x_wrap = (pixel_x == H_LAST);
      y_wrap = x_wrap && (pixel_y == V_LAST);
      x_next = x_wrap ? '0 : pixel_x + 10'd1;
      y_next = pixel_y;
      if (x_wrap) begin
         y_next = y_wrap ? '0 : pixel_y + 10'd1;
      end
   end

   // Decodes use the next coordinates so they register in step with pixel_x/pixel_y.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pixel_x     <= '0;
         pixel_y     <= '0;
         hsync       <= ~SYNC_ON;
         vsync       <= ~SYNC_ON;
         video_on    <= 1'b0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         frame_count <= '0;
      end else if (pixel_en) begin
         pixel_x     <= x_next;
         pixel_y     <= y_next;
         line_start  <= x_wrap;
         frame_start <= y_wrap;
         frame_count <= frame_count + 8'(y_wrap);
         video_on    <= (x_next < H_VIS) && (y_next < V_VIS);
         hsync       <= ((x_next >= HS_START) && (x_next < HS_END)) ? SYNC_ON : ~SYNC_ON;
         vsync       <= ((y_next >= VS_START) && (y_next < VS_END)) ? SYNC_ON : ~SYNC_ON;
      end else begin
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end
   end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: full 640x480 geometry plus a reduced geometry (active-high sync)
// so whole frames and the 256-frame counter wrap fit in a short run.
module tb_vga_sync_gen;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic pixel_en = 1'b0;

   always #5 clock = ~clock;

   logic [9:0] f_x, f_y, s_x, s_y;
   logic       f_hs, f_vs, f_vid, f_ls, f_fs;
   logic       s_hs, s_vs, s_vid, s_ls, s_fs;
   logic [7:0] f_fc, s_fc;

   vga_sync_gen u_full (
      .clock(clock), .reset(reset), .pixel_en(pixel_en),
      .pixel_x(f_x), .pixel_y(f_y), .hsync(f_hs), .vsync(f_vs), .video_on(f_vid),
      .line_start(f_ls), .frame_start(f_fs), .frame_count(f_fc)
   );

   vga_sync_gen #(
      .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
      .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
      .SYNC_ACTIVE(1)
   ) u_small (
      .clock(clock), .reset(reset), .pixel_en(pixel_en),
      .pixel_x(s_x), .pixel_y(s_y), .hsync(s_hs), .vsync(s_vs), .video_on(s_vid),
      .line_start(s_ls), .frame_start(s_fs), .frame_count(s_fc)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: total enabled ticks since reset; everything else follows by division.
   longint ticks = 0;
   logic   m_f_ls = 1'b0, m_f_fs = 1'b0, m_s_ls = 1'b0, m_s_fs = 1'b0;

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         ticks  <= 0;
         m_f_ls <= 1'b0;
         m_f_fs <= 1'b0;
         m_s_ls <= 1'b0;
         m_s_fs <= 1'b0;
      end else if (pixel_en) begin
         ticks  <= ticks + 1;
         m_f_ls <= ((ticks + 1) % 800) == 0;
         m_f_fs <= ((ticks + 1) % 420000) == 0;
         m_s_ls <= ((ticks + 1) % 15) == 0;
         m_s_fs <= ((ticks + 1) % 135) == 0;
      end else begin
         m_f_ls <= 1'b0;
         m_f_fs <= 1'b0;
         m_s_ls <= 1'b0;
         m_s_fs <= 1'b0;
      end
   end

   task automatic cmp(input string tag, input int hv, hf, hs, hb, vv, vf, vs, vb, sa,
                      input logic e_ls, e_fs,
                      input logic [9:0] ax, ay, input logic ahs, avs, avid, als, afs,
                      input logic [7:0] afc);
      longint ht = hv + hf + hs + hb;
      longint vt = vv + vf + vs + vb;
      longint ex = ticks % ht;
      longint ey = (ticks / ht) % vt;
      longint efc = (ticks / (ht * vt)) % 256;
      logic on = (sa != 0);
      logic evid = (ticks != 0) && (ex < hv) && (ey < vv);
      logic ehs = (ex >= hv + hf && ex < hv + hf + hs) ? on : ~on;
      logic evs = (ey >= vv + vf && ey < vv + vf + vs) ? on : ~on;
      chk({tag, ".pixel_x"}, 32'(ax), 32'(ex));
      chk({tag, ".pixel_y"}, 32'(ay), 32'(ey));
      chk({tag, ".hsync"}, 32'(ahs), 32'(ehs));
      chk({tag, ".vsync"}, 32'(avs), 32'(evs));
      chk({tag, ".video_on"}, 32'(avid), 32'(evid));
      chk({tag, ".line_start"}, 32'(als), 32'(e_ls));
      chk({tag, ".frame_start"}, 32'(afs), 32'(e_fs));
      chk({tag, ".frame_count"}, 32'(afc), 32'(efc));
   endtask

   always @(negedge clock) begin
      cmp("full", 640, 16, 96, 48, 480, 10, 2, 33, 0, m_f_ls, m_f_fs,
          f_x, f_y, f_hs, f_vs, f_vid, f_ls, f_fs, f_fc);
      cmp("small", 8, 2, 3, 2, 4, 1, 2, 2, 1, m_s_ls, m_s_fs,
          s_x, s_y, s_hs, s_vs, s_vid, s_ls, s_fs, s_fc);
   end

   int hs_low;

   initial begin
      repeat (3) @(negedge clock);
      chk("rst.x", 32'(f_x), 0);
      chk("rst.y", 32'(f_y), 0);
      chk("rst.hsync", 32'(f_hs), 1);
      chk("rst.vsync", 32'(f_vs), 1);
      chk("rst.video_on", 32'(f_vid), 0);
      chk("rst.small_hsync", 32'(s_hs), 0);
      reset = 1'b0;

      // Continuous ticks: 256 small frames, with literal pins at known points.
      pixel_en = 1'b1;
      for (int k = 1; k <= 256 * 135; k++) begin
         @(negedge clock);
         if (k == 134) begin
            chk("pin.s134.x", 32'(s_x), 14);
            chk("pin.s134.y", 32'(s_y), 8);
         end
         if (k == 135) begin
            chk("pin.s135.x", 32'(s_x), 0);
            chk("pin.s135.y", 32'(s_y), 0);
            chk("pin.s135.ls", 32'(s_ls), 1);
            chk("pin.s135.fs", 32'(s_fs), 1);
            chk("pin.s135.vid", 32'(s_vid), 1);
            chk("pin.s135.hs", 32'(s_hs), 0);
            chk("pin.s135.vs", 32'(s_vs), 0);
            chk("pin.s135.fc", 32'(s_fc), 1);
         end
         if (k == 136) chk("pin.s136.fs_width", 32'(s_fs), 0);
         if (k == 655) chk("pin.f655.hs", 32'(f_hs), 1);
         if (k == 656) begin
            chk("pin.f656.x", 32'(f_x), 656);
            chk("pin.f656.hs", 32'(f_hs), 0);
         end
         if (k == 752) chk("pin.f752.hs", 32'(f_hs), 1);
         if (k == 800) begin
            chk("pin.f800.x", 32'(f_x), 0);
            chk("pin.f800.y", 32'(f_y), 1);
            chk("pin.f800.ls", 32'(f_ls), 1);
         end
         if (k == 255 * 135) chk("pin.fc255", 32'(s_fc), 255);
         if (k == 256 * 135) begin
            chk("pin.fc_wrap", 32'(s_fc), 0);
            chk("pin.fc_wrap_fs", 32'(s_fs), 1);
         end
      end

      // One-in-four enable: a full hsync pulse spans 96 ticks = 384 clocks.
      hs_low = 0;
      for (int i = 0; i < 4000; i++) begin
         pixel_en = (i % 4) == 0;
         @(negedge clock);
         if (!f_hs) hs_low++;
      end
      chk("hsync_clocks_1of4", 32'(hs_low), 384);

      for (int i = 0; i < 5000; i++) begin
         pixel_en = 1'($urandom_range(0, 1));
         @(negedge clock);
      end

      // Asynchronous reset mid-frame, sampled before any clock edge.
      pixel_en = 1'b1;
      @(negedge clock);
      #2 reset = 1'b1;
      #1;
      chk("arst.x", 32'(f_x), 0);
      chk("arst.y", 32'(f_y), 0);
      chk("arst.hsync", 32'(f_hs), 1);
      chk("arst.vsync", 32'(f_vs), 1);
      chk("arst.video_on", 32'(f_vid), 0);
      chk("arst.frame_count", 32'(f_fc), 0);
      chk("arst.small_fc", 32'(s_fc), 0);
      repeat (2) @(negedge clock);
      reset = 1'b0;

      for (int i = 0; i < 2000; i++) begin
         pixel_en = ($urandom_range(0, 3) != 0);
         @(negedge clock);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
